shared_adder_arbiter: RTL and testbench
=======================================

# shared_adder_arbiter

Round-robin arbiter and sequencer sharing one parameterized adder datapath among four requesters. Each requester presents two operands under a request/grant handshake. The block latches the winner's operands, computes a wrap-around sum, and holds the tagged result behind a valid/ready output handshake. It sits between the requesting client logic and a single adder instance, so only one adder is synthesized.

## Interface
- msb, 3, MSB index of operand and result vectors
- lsb, 0, LSB index of operand and result vectors; W = msb-lsb+1
- clk  input  1  sole clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- req  input  4  per-requester request, bit i = requester i
- a0, a1, a2, a3  input  [msb:lsb]  operand A of requester i
- b0, b1, b2, b3  input  [msb:lsb]  operand B of requester i
- gnt  output  4  one-hot, registered; one-cycle pulse marks the operands accepted
- out_valid  output  1  result register holds an undelivered sum
- out_sum  output  [msb:lsb]  (a_i + b_i) mod 2^W
- out_id  output  2  index of requester that produced out_sum
- out_ready  input  1  consumer accepts result when high with out_valid

## Operation
- FSM states: IDLE, CALC, HOLD. Reset state IDLE.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick the winner by round-robin and latch a_w, b_w into operand regs and w into id reg.
  - Set gnt <= one-hot(w), set last <= w, go to CALC.
- Round-robin: search order last+1, last+2, last+3, last+4 (mod 4); first set req bit wins. last resets to 3, so requester 0 has top priority after reset.
- CALC:
  - gnt = one-hot(w) for this cycle only; it is cleared at the end of CALC.
  - sum_reg <= opa + opb truncated to W bits; carry discarded.
  - out_valid <= 1, go to HOLD.
  - req is not sampled in CALC.
- HOLD:
  - out_valid, out_sum, out_id held stable.
  - If out_ready == 1: out_valid <= 0, go to IDLE.
  - req is not sampled in HOLD. The winner is not re-arbitrated in the same cycle as out_ready.
- Requester protocol:
  - Hold req and operands stable until gnt[i] is seen.
  - Drop req, or present the next operands, in or after the gnt cycle.
  - Operands are sampled only at the IDLE edge.
- Arithmetic: unsigned, W-bit, modulo 2^W (e.g. W=4: 9+9 -> 2).
- No output overflow is possible: a single result register, and no acceptance while out_valid = 1.

## Timing
- Reset values: gnt=0, out_valid=0, out_sum=0, out_id=0, state=IDLE, last=3, operand and id regs = 0.
- Reset mid-operation (CALC or HOLD): pending result discarded, out_valid=0 next cycle, pointer back to 3. No gnt may appear in the cycle after reset.
- Cycle timing, with request sampled at edge k:
  - gnt high during cycle k..k+1.
  - out_valid high from edge k+1.
  - If out_ready is already 1, out_valid drops at edge k+2, IDLE resumes, and the next sample is at edge k+3.
- Maximum throughput: one operation per 3 cycles.
- Backpressure adds one cycle per out_ready-low cycle in HOLD.
- Simultaneous requests: exactly one gnt bit per acceptance; never more than one bit set.
- A requester that deasserts req before being granted is simply skipped.
- Pointer updates only on acceptance.
- out_ready while out_valid=0 has no effect.

## Test plan
- Reset: assert reset 2 cycles with req=4'b1111 -> gnt=0, out_valid=0, out_sum=0, out_id=0. First grant after release goes to requester 0.
- Single request (msb=3, lsb=0): req=4'b0010, a1=5, b1=6 at edge k:
  - gnt=4'b0010 for exactly one cycle.
  - out_valid=1 at edge k+1 with out_sum=11, out_id=1.
  - out_ready=1 -> out_valid=0 at edge k+2.
- Wrap-around: a2=9, b2=9 -> out_sum=2, out_id=2. Also a3=15, b3=15 -> out_sum=14.
- Fairness: req=4'b1111 held for 15 cycles with out_ready=1 -> grant sequence 0,1,2,3,0, spaced 3 cycles apart. Then req=4'b1010 -> grants continue 1,3,1.
- Backpressure: result valid, out_ready=0 for 5 cycles with req=4'b0001 pending -> out_valid, out_sum, out_id stable and no gnt. out_ready=1 -> out_valid drops next edge, gnt[0] arrives 1 cycle later.
- Reset in HOLD: out_valid=1 with sum 7, assert reset one cycle -> out_valid=0, out_sum=0. With req=4'b1000 afterwards -> gnt=4'b1000, and the pointer restarts from 3 (so req=4'b1001 grants 0 first).

Source files
------------

// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter
//   Round-robin arbiter that shares one W-bit adder among four requesters.
//   The winner's operands are latched in IDLE, summed in CALC, and the tagged
//   result is held in HOLD until the consumer takes it.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   req        per-requester request, bit i = requester i
//   a0..a3     operand A of requester i
//   b0..b3     operand B of requester i
//   gnt        registered one-hot grant, one-cycle pulse on acceptance
//   out_valid  result register holds an undelivered sum
//   out_sum    (a_w + b_w) mod 2^W
//   out_id     index of the requester that produced out_sum
//   out_ready  consumer accepts the result when high with out_valid

module shared_adder_arbiter #(
    parameter int msb = 3,
    parameter int lsb = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [msb:lsb]   a0,
    input  logic [msb:lsb]   a1,
    input  logic [msb:lsb]   a2,
    input  logic [msb:lsb]   a3,
    input  logic [msb:lsb]   b0,
    input  logic [msb:lsb]   b1,
    input  logic [msb:lsb]   b2,
    input  logic [msb:lsb]   b3,
    output logic [3:0]       gnt,
    output logic             out_valid,
    output logic [msb:lsb]   out_sum,
    output logic [1:0]       out_id,
    input  logic             out_ready
);

    typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

    state_e         state_q, state_d;
    logic [1:0]     last_q;
    logic [1:0]     id_q;
    logic [msb:lsb] opa_q, opb_q;
    logic [msb:lsb] sum_q;
    logic [3:0]     gnt_q, gnt_d;
    logic           valid_q, valid_d;

    logic           accept;
    logic [1:0]     winner;
    logic [msb:lsb] a_sel, b_sel;

    // Search last+1 .. last+4 (mod 4); the first set request wins.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        a_sel = a0;
        b_sel = b0;
        unique case (winner)
            2'd0: begin a_sel = a0; b_sel = b0; end
            2'd1: begin a_sel = a1; b_sel = b1; end
            2'd2: begin a_sel = a2; b_sel = b2; end
            2'd3: begin a_sel = a3; b_sel = b3; end
            default: ;
        endcase
    end

    assign accept = (state_q == StIdle) && (|req);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|req) state_d = StCalc;
            StCalc:  state_d = StHold;
            StHold:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic: next values of the registered handshake outputs
    always_comb begin
        gnt_d   = accept ? (4'b0001 << winner) : 4'b0000;
        valid_d = (state_d == StHold);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q  <= 2'd3;
            id_q    <= 2'd0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            if (accept) begin
                opa_q  <= a_sel;
                opb_q  <= b_sel;
                id_q   <= winner;
                last_q <= winner;
            end
            // The single shared adder; carry out is dropped.
            if (state_q == StCalc) begin
                sum_q <= opa_q + opb_q;
            end
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
module tb_shared_adder_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic [3:0] gnt;
    logic       out_valid;
    logic [3:0] out_sum;
    logic [1:0] out_id;
    logic       out_ready;

    int checks;
    int failures;

    // Expected {id, sum} of every result the consumer is going to accept.
    logic [5:0] exp_q[$];

    shared_adder_arbiter #(.msb(3), .lsb(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a0        (a0),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .b3        (b3),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a result is delivered at the next rising edge when valid and ready.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            logic [5:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result got id=%0d sum=%0d", out_id, out_sum);
            end else begin
                e = exp_q.pop_front();
                check("result_id", {30'd0, out_id}, {30'd0, e[5:4]});
                check("result_sum", {28'd0, out_sum}, {28'd0, e[3:0]});
            end
        end
    end

    // One isolated operation with out_ready already high.
    task automatic single(input int idx, input logic [3:0] exp_sum);
        req       = 4'b0001 << idx;
        out_ready = 1'b1;
        exp_q.push_back({2'(idx), exp_sum});
        tick();
        check("single_gnt", {28'd0, gnt}, 32'(4'b0001 << idx));
        check("single_valid_early", {31'd0, out_valid}, 32'd0);
        req = 4'b0000;
        tick();
        check("single_gnt_pulse", {28'd0, gnt}, 32'd0);
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_sum", {28'd0, out_sum}, {28'd0, exp_sum});
        check("single_id", {30'd0, out_id}, 32'(idx));
        tick();
        check("single_valid_drop", {31'd0, out_valid}, 32'd0);
    endtask

    // Hand-computed sums for operands a/b below: 1+2, 5+6, 9+9, 15+15 (mod 16).
    logic [3:0] sum_tab [4];
    int         fair_seq [5];
    int         alt_seq [3];

    initial begin
        sum_tab  = '{4'd3, 4'd11, 4'd2, 4'd14};
        fair_seq = '{0, 1, 2, 3, 0};
        alt_seq  = '{1, 3, 1};
        checks   = 0;
        failures = 0;

        a0 = 4'd1;  b0 = 4'd2;
        a1 = 4'd5;  b1 = 4'd6;
        a2 = 4'd9;  b2 = 4'd9;
        a3 = 4'd15; b3 = 4'd15;

        // Reset with all requests asserted.
        reset     = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {28'd0, out_sum}, 32'd0);
        check("rst_id", {30'd0, out_id}, 32'd0);
        reset = 1'b0;

        // First grant after reset goes to requester 0.
        single(0, 4'd3);

        // Single request and wrap-around cases.
        single(1, 4'd11);
        single(2, 4'd2);
        single(3, 4'd14);

        // Fairness: all four requesting, pointer currently at 3.
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i % 3 == 0) begin
                exp_q.push_back({2'(fair_seq[i / 3]), sum_tab[fair_seq[i / 3]]});
            end
            tick();
            if (i % 3 == 0) begin
                check("fair_gnt", {28'd0, gnt}, 32'(4'b0001 << fair_seq[i / 3]));
            end else begin
                check("fair_gap", {28'd0, gnt}, 32'd0);
            end
        end
        req = 4'b1010;
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 0) begin
                exp_q.push_back({2'(alt_seq[i / 3]), sum_tab[alt_seq[i / 3]]});
            end
            tick();
            if (i % 3 == 0) begin
                check("alt_gnt", {28'd0, gnt}, 32'(4'b0001 << alt_seq[i / 3]));
            end else begin
                check("alt_gap", {28'd0, gnt}, 32'd0);
            end
        end

        // Backpressure with requester 0 still requesting.
        req       = 4'b0001;
        out_ready = 1'b0;
        exp_q.push_back({2'd0, 4'd3});
        tick();
        check("bp_gnt", {28'd0, gnt}, 32'h1);
        tick();
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_sum", {28'd0, out_sum}, 32'd3);
            check("bp_hold_id", {30'd0, out_id}, 32'd0);
            check("bp_hold_gnt", {28'd0, gnt}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_gnt", {28'd0, gnt}, 32'd0);
        exp_q.push_back({2'd0, 4'd3});
        tick();
        check("bp_next_gnt", {28'd0, gnt}, 32'h1);
        req = 4'b0000;
        tick();
        tick();
        check("bp_done", {31'd0, out_valid}, 32'd0);

        // Reset while holding a result of 3+4.
        a2        = 4'd3;
        b2        = 4'd4;
        req       = 4'b0100;
        out_ready = 1'b0;
        tick();
        check("rh_gnt", {28'd0, gnt}, 32'h4);
        req = 4'b0000;
        tick();
        check("rh_valid", {31'd0, out_valid}, 32'd1);
        check("rh_sum", {28'd0, out_sum}, 32'd7);
        reset = 1'b1;
        tick();
        check("rh_rst_valid", {31'd0, out_valid}, 32'd0);
        check("rh_rst_sum", {28'd0, out_sum}, 32'd0);
        check("rh_rst_id", {30'd0, out_id}, 32'd0);
        check("rh_rst_gnt", {28'd0, gnt}, 32'd0);
        reset = 1'b0;

        // Pointer back at 3: requester 0 beats requester 3.
        req       = 4'b1001;
        out_ready = 1'b1;
        exp_q.push_back({2'd0, 4'd3});
        tick();
        check("rh_ptr_gnt", {28'd0, gnt}, 32'h1);
        req = 4'b0000;
        tick();
        tick();
        req = 4'b1000;
        exp_q.push_back({2'd3, 4'd14});
        tick();
        check("rh_gnt3", {28'd0, gnt}, 32'h8);
        req = 4'b0000;
        tick();
        tick();
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
